pyrm_writeback_block: RTL and testbench

Writeback queue on the register-file write side of the pipeline. Collects completed results from the ALU and the load unit over valid/ready handshakes, formats load data (sign/zero extension by funct3), buffers up to DEPTH results in order, and drains one per cycle onto the register file's `write` / `reg_addr` / `reg_data` port. Also answers hazard queries for two source registers against still-pending writes.

---
 rtl/pyrm_pkg.sv | 24 ++
 rtl/pyrm_load_format.sv | 24 ++
 rtl/pyrm_writeback_block.sv | 117 +++++++++++
 tb/tb_pyrm_writeback_block.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pyrm_pkg.sv
// Shared types and constants for the writeback queue.
package pyrm_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    // Load width/sign encodings carried on funct3.
    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } load_f3_e;

    // One queued register-file write.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/pyrm_load_format.sv
// Sign/zero extension of right-aligned load data selected by funct3.
module pyrm_load_format
    import pyrm_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] data_o
);

    // Encoding 3'b111 has no enum member and falls to the pass-through default.
    always_comb begin
        data_o = raw_i;
        case (load_f3_e'(funct3_i))
            F3_LB:   data_o = {{(XLEN-8){raw_i[7]}},   raw_i[7:0]};
            F3_LH:   data_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            F3_LW:   data_o = {{(XLEN-32){raw_i[31]}}, raw_i[31:0]};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}},       raw_i[7:0]};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}},      raw_i[15:0]};
            F3_LWU:  data_o = {{(XLEN-32){1'b0}},      raw_i[31:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/pyrm_writeback_block.sv
// Writeback queue: accepts load and ALU results, buffers them in order and
// drains one per cycle to the register file; answers source-register hazard
// queries against pending writes. XLEN must match the package entry width.
module pyrm_writeback_block #(
    parameter int DEPTH = 4,
    parameter int XLEN  = pyrm_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [4:0]                 ld_rd,
    input  logic [2:0]                 ld_funct3,
    input  logic [XLEN-1:0]            ld_raw,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       wb_stall,
    output logic                       write,
    output logic [XLEN-1:0]            reg_addr,
    output logic [XLEN-1:0]            reg_data,
    input  logic [4:0]                 q_rs1,
    input  logic [4:0]                 q_rs2,
    output logic                       pend1,
    output logic                       pend2,
    output logic [$clog2(DEPTH):0]     count
);
    import pyrm_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       fifo_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   free;
    logic [XLEN-1:0] ld_fmt;
    logic            ld_push, alu_push, pop;
    logic [PW-1:0]   alu_slot;
    logic [DEPTH-1:0] live;
    wb_entry_t       head_entry;

    pyrm_load_format u_load_format (
        .funct3_i (ld_funct3),
        .raw_i    (ld_raw),
        .data_o   (ld_fmt)
    );

    // Room is judged on the registered count only; a same-cycle pop does not help.
    assign free      = CW'(DEPTH) - count_q;
    assign ld_ready  = reset_n && (free >= CW'(1));
    assign alu_ready = reset_n && (free >= (CW'(1) + CW'(ld_valid)));

    // Results for x0 finish their handshake but never occupy a slot.
    assign ld_push  = ld_valid && ld_ready && (ld_rd != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

    // The load is older, so the ALU result lands one slot behind it when both push.
    assign alu_slot = tail_q + PW'(ld_push);

    assign head_entry = fifo_q[head_q];
    assign pop        = write;
    assign write      = (count_q != '0) && !wb_stall;
    assign reg_addr   = write ? {{(XLEN-REG_AW){1'b0}}, head_entry.rd} : '0;
    assign reg_data   = write ? head_entry.data : '0;
    assign count      = count_q;

    // Next-state pointer and occupancy arithmetic.
    always_comb begin
        tail_d  = tail_q + PW'(ld_push) + PW'(alu_push);
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            fifo_q[tail_q] <= '{rd: ld_rd, data: ld_fmt};
        end
        if (alu_push) begin
            fifo_q[alu_slot] <= '{rd: alu_rd, data: alu_data};
        end
    end

    // Hazard compare across every occupied slot, head included.
    always_comb begin
        logic [PW-1:0] off;
        off   = '0;
        live  = '0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off     = PW'(i) - head_q;
            live[i] = ({1'b0, off} < count_q);
            if (live[i] && (fifo_q[i].rd == q_rs1)) pend1 = 1'b1;
            if (live[i] && (fifo_q[i].rd == q_rs2)) pend2 = 1'b1;
        end
        if (q_rs1 == '0) pend1 = 1'b0;
        if (q_rs2 == '0) pend2 = 1'b0;
    end

endmodule

// File: tb/tb_pyrm_writeback_block.sv
// Scoreboard bench for the writeback queue: stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_pyrm_writeback_block;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_valid, alu_valid, wb_stall;
    logic        ld_ready, alu_ready, write, pend1, pend2;
    logic [4:0]  ld_rd, alu_rd, q_rs1, q_rs2;
    logic [2:0]  ld_funct3;
    logic [63:0] ld_raw, alu_data, reg_addr, reg_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [68:0] exp_q [$];

    always #5 clk = ~clk;

    pyrm_writeback_block #(.DEPTH(4), .XLEN(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_funct3 (ld_funct3),
        .ld_raw    (ld_raw),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .wb_stall  (wb_stall),
        .write     (write),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .pend1     (pend1),
        .pend2     (pend2),
        .count     (count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
        logic [68:0] e;
        if (write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h/%h required=none", reg_addr, reg_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", reg_addr, {59'b0, e[68:64]});
                chk("wb_data", reg_data, e[63:0]);
            end
        end
    end

    // Offer one or both sources until accepted; called and returns at posedge+1.
    task automatic offer(input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                         input logic [63:0] raw, input logic [63:0] lexp,
                         input bit av, input logic [4:0] ard, input logic [63:0] adat);
        bit ld_done, alu_done, la, aa;
        int n;
        ld_done = !lv; alu_done = !av; n = 0;
        ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_raw = raw;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        while (!(ld_done && alu_done)) begin
            @(negedge clk);
            la = ld_valid && ld_ready;
            aa = alu_valid && alu_ready;
            @(posedge clk);
            if (la) begin
                if (lrd != 0) exp_q.push_back({lrd, lexp});
                ld_done = 1;
            end
            if (aa) begin
                if (ard != 0) exp_q.push_back({ard, adat});
                alu_done = 1;
            end
            #1;
            if (la) ld_valid = 1'b0;
            if (aa) alu_valid = 1'b0;
            n++;
            if (n > 20 && !(ld_done && alu_done)) begin
                checks++;
                errors++;
                $display("FAIL offer_timeout actual=not_accepted required=accepted");
                ld_valid = 1'b0; alu_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (count != 0 && n < 50);
        chk("drain_idle", 64'(count), 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct { logic [2:0] f3; logic [63:0] exp; } ext_t;
    ext_t ext_tab [8];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; wb_stall = 1'b0;
        ld_valid = 1'b0; alu_valid = 1'b0;
        ld_rd = '0; alu_rd = '0; ld_funct3 = '0; ld_raw = '0; alu_data = '0;
        q_rs1 = 5'd5; q_rs2 = 5'd6;

        // Reset: readies forced low, then everything quiet.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_addr", reg_addr, 64'd0);
        chk("rst_data", reg_data, 64'd0);
        chk("rst_pend1", 64'(pend1), 64'd0);
        chk("rst_pend2", 64'(pend2), 64'd0);
        @(posedge clk); #1;

        // Dual push: load older than ALU, first write the cycle after accept.
        offer(1, 5'd5, 3'b000, 64'h80, 64'hFFFF_FFFF_FFFF_FF80,
              1, 5'd6, 64'h1234);
        @(negedge clk);
        chk("latency_write", 64'(write), 64'd1);
        @(posedge clk); #1;
        wait_idle();

        // Extension sweep.
        ext_tab[0] = '{3'b100, 64'h0000_0000_0000_0080};
        ext_tab[1] = '{3'b101, 64'h0000_0000_0000_8080};
        ext_tab[2] = '{3'b001, 64'hFFFF_FFFF_FFFF_8080};
        ext_tab[3] = '{3'b010, 64'hFFFF_FFFF_8000_8080};
        ext_tab[4] = '{3'b110, 64'h0000_0000_8000_8080};
        ext_tab[5] = '{3'b000, 64'hFFFF_FFFF_FFFF_FF80};
        ext_tab[6] = '{3'b011, 64'hFFFF_FFFF_8000_8080};
        ext_tab[7] = '{3'b111, 64'hFFFF_FFFF_8000_8080};
        for (int i = 0; i < 8; i++) begin
            offer(1, 5'(i + 1), ext_tab[i].f3, 64'hFFFF_FFFF_8000_8080, ext_tab[i].exp,
                  0, 5'd0, 64'd0);
        end
        wait_idle();

        // x0 result: handshake completes, nothing queued.
        offer(0, 5'd0, 3'd0, 64'd0, 64'd0, 1, 5'd0, 64'hDEAD);
        @(negedge clk);
        chk("x0_count", 64'(count), 64'd0);
        chk("x0_write", 64'(write), 64'd0);
        repeat (3) @(posedge clk); #1;

        // Backpressure under stall.
        wb_stall = 1'b1;
        offer(0, 5'd0, 3'd0, 64'd0, 64'd0, 1, 5'd10, 64'h10);
        offer(0, 5'd0, 3'd0, 64'd0, 64'd0, 1, 5'd11, 64'h11);
        offer(0, 5'd0, 3'd0, 64'd0, 64'd0, 1, 5'd12, 64'h12);
        ld_valid = 1'b1; ld_rd = 5'd13; ld_funct3 = 3'b011; ld_raw = 64'h13;
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 64'h14;
        @(negedge clk);
        chk("bp_count3", 64'(count), 64'd3);
        chk("bp_ld_ready", 64'(ld_ready), 64'd1);
        chk("bp_alu_ready", 64'(alu_ready), 64'd0);
        @(posedge clk);
        exp_q.push_back({5'd13, 64'h13});
        #1 ld_valid = 1'b0;
        @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ld_ready", 64'(ld_ready), 64'd0);
        chk("full_alu_ready", 64'(alu_ready), 64'd0);
        @(posedge clk); #1 wb_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit aa;
            @(negedge clk);
            chk("consec_write", 64'(write), 64'd1);
            aa = alu_valid && alu_ready;
            @(posedge clk);
            if (aa) exp_q.push_back({5'd14, 64'h14});
            #1;
            if (aa) alu_valid = 1'b0;
        end
        @(negedge clk);
        chk("bp_done_write", 64'(write), 64'd0);
        @(posedge clk); #1;

        // Hazard query against a held entry.
        wb_stall = 1'b1;
        offer(0, 5'd0, 3'd0, 64'd0, 64'd0, 1, 5'd7, 64'h77);
        q_rs1 = 5'd7; q_rs2 = 5'd0;
        @(negedge clk);
        chk("haz_pend1", 64'(pend1), 64'd1);
        chk("haz_pend2_x0", 64'(pend2), 64'd0);
        q_rs2 = 5'd7; #1;
        chk("haz_pend2_hit", 64'(pend2), 64'd1);
        q_rs2 = 5'd3; #1;
        chk("haz_pend2_miss", 64'(pend2), 64'd0);
        @(posedge clk); #1 wb_stall = 1'b0;
        @(negedge clk);
        chk("haz_write", 64'(write), 64'd1);
        chk("haz_pend1_held", 64'(pend1), 64'd1);
        @(negedge clk);
        chk("haz_pend1_drop", 64'(pend1), 64'd0);
        @(posedge clk); #1;

        // Reset with entries queued: nothing of the old contents drains.
        wb_stall = 1'b1;
        offer(1, 5'd20, 3'b011, 64'h20, 64'h20, 1, 5'd21, 64'h21);
        offer(0, 5'd0, 3'd0, 64'd0, 64'd0, 1, 5'd22, 64'h22);
        @(negedge clk);
        chk("mid_count3", 64'(count), 64'd3);
        reset_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_write", 64'(write), 64'd0);
        @(posedge clk); #1 wb_stall = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_quiet", 64'(write), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
